// File: rtl/uart_tx_fmt_if.sv
// FIFO push side of uart_tx_fmt: write strobe/data from the register file,
// occupancy flags back to it.
interface uart_tx_fmt_if #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16
);
    logic                          we_i;
    logic [DATA_WIDTH-1:0]         din_i;
    logic                          full_o;
    logic                          empty_o;
    logic [$clog2(FIFO_DEPTH):0]   level_o;

    modport master (output we_i, din_i, input full_o, empty_o, level_o);
    modport slave  (input we_i, din_i, output full_o, empty_o, level_o);
endinterface

// File: rtl/uart_tx_fmt.sv
// Configurable-format UART transmitter (5..DATA_WIDTH data bits, parity,
// 1/2 stop bits, break) fed from an internal FIFO.
module uart_tx_fmt #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_WIDTH  = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [DIV_WIDTH-1:0]              baud_div_i,
    input  logic                              tx_en_i,
    input  logic [$clog2(DATA_WIDTH+1)-1:0]   cfg_nbits_i,
    input  logic [1:0]                        cfg_parity_i,
    input  logic                              cfg_stop2_i,
    input  logic                              break_i,
    uart_tx_fmt_if.slave                      bus,
    output logic                              busy_o,
    output logic                              done_o,
    output logic                              tx_o
);
    localparam int NBW = $clog2(DATA_WIDTH + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int LW  = AW + 1;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]         level_q, level_nxt;
    logic                  full_q, empty_q;
    logic                  push, pop;

    state_t                state_q;
    logic [DIV_WIDTH-1:0]  cnt_q, p_m1;
    logic [DATA_WIDTH-1:0] sh_q, mask, head_masked;
    logic [NBW-1:0]        bit_idx_q, nm1_q, n_cl;
    logic                  par_en_q, par_bit_q, stop2_q, stop_left_q, brk_q, tx_q;
    logic                  ld_par, start_ok, stop_final;

    assign push = bus.we_i && !full_q;

    always_comb begin
        level_nxt = level_q;
        if (push && !pop)
            level_nxt = level_q + LW'(1);
        else if (!push && pop)
            level_nxt = level_q - LW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (push)
            mem[wr_ptr_q] <= bus.din_i;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_nxt;
            full_q  <= (level_nxt == LW'(FIFO_DEPTH));
            empty_q <= (level_nxt == '0);
        end
    end

    assign bus.full_o  = full_q;
    assign bus.empty_o = empty_q;
    assign bus.level_o = level_q;

    // Frame format is captured from the FIFO head and cfg_* at the pop cycle.
    always_comb begin
        if (cfg_nbits_i < NBW'(5))
            n_cl = NBW'(5);
        else if (cfg_nbits_i > NBW'(DATA_WIDTH))
            n_cl = NBW'(DATA_WIDTH);
        else
            n_cl = cfg_nbits_i;
        mask = '0;
        for (int unsigned i = 0; i < DATA_WIDTH; i++)
            mask[i] = (i < 32'(n_cl));
        head_masked = mem[rd_ptr_q] & mask;
        case (cfg_parity_i)
            2'b01:   ld_par = ^head_masked;
            2'b10:   ld_par = ~(^head_masked);
            default: ld_par = 1'b1;
        endcase
        p_m1 = (baud_div_i == '0) ? '0 : baud_div_i - DIV_WIDTH'(1);
    end

    assign start_ok   = !break_i && tx_en_i && !empty_q;
    assign stop_final = (state_q == S_STOP) && (cnt_q == '0) && !stop_left_q;
    assign pop        = start_ok && ((state_q == S_IDLE) || (stop_final && !brk_q));
    assign done_o     = stop_final && !brk_q;
    assign busy_o     = (state_q != S_IDLE);
    assign tx_o       = tx_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            bit_idx_q   <= '0;
            nm1_q       <= '0;
            par_en_q    <= 1'b0;
            par_bit_q   <= 1'b0;
            stop2_q     <= 1'b0;
            stop_left_q <= 1'b0;
            brk_q       <= 1'b0;
            tx_q        <= 1'b1;
        end else if (pop) begin
            // Covers both the idle start and the zero-gap chained start.
            state_q   <= S_START;
            cnt_q     <= p_m1;
            sh_q      <= head_masked;
            bit_idx_q <= '0;
            nm1_q     <= n_cl - NBW'(1);
            par_en_q  <= |cfg_parity_i;
            par_bit_q <= ld_par;
            stop2_q   <= cfg_stop2_i;
            brk_q     <= 1'b0;
            tx_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (break_i) begin
                        state_q <= S_BREAK;
                        brk_q   <= 1'b1;
                        tx_q    <= 1'b0;
                    end
                end
                S_START: begin
                    if (cnt_q == '0) begin
                        state_q <= S_DATA;
                        cnt_q   <= p_m1;
                        tx_q    <= sh_q[0];
                    end else begin
                        cnt_q <= cnt_q - DIV_WIDTH'(1);
                    end
                end
                S_DATA: begin
                    if (cnt_q == '0) begin
                        cnt_q <= p_m1;
                        if (bit_idx_q == nm1_q) begin
                            if (par_en_q) begin
                                state_q <= S_PARITY;
                                tx_q    <= par_bit_q;
                            end else begin
                                state_q     <= S_STOP;
                                stop_left_q <= stop2_q;
                                tx_q        <= 1'b1;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + NBW'(1);
                            sh_q      <= sh_q >> 1;
                            tx_q      <= sh_q[1];
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_WIDTH'(1);
                    end
                end
                S_PARITY: begin
                    if (cnt_q == '0) begin
                        state_q     <= S_STOP;
                        cnt_q       <= p_m1;
                        stop_left_q <= stop2_q;
                        tx_q        <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - DIV_WIDTH'(1);
                    end
                end
                S_STOP: begin
                    if (cnt_q == '0) begin
                        if (stop_left_q) begin
                            stop_left_q <= 1'b0;
                            cnt_q       <= p_m1;
                        end else begin
                            state_q <= S_IDLE;
                            brk_q   <= 1'b0;
                            tx_q    <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - DIV_WIDTH'(1);
                    end
                end
                S_BREAK: begin
                    if (!break_i) begin
                        state_q     <= S_STOP;
                        cnt_q       <= p_m1;
                        stop_left_q <= 1'b0;
                        tx_q        <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
